// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings, FSM state type and lane-mask helper for the data-memory responder
//   SIZE_B/SIZE_H/SIZE_W : req_size_i encodings (2'b11 is illegal)
//   state_t              : responder FSM states
//   LATENCY_MAX          : largest supported wait-state count
//   lane_mask()          : 4-bit byte-lane enable from size and addr[1:0]
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int LATENCY_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned combinations are rejected before a write, so the mask only
  // has to be right for aligned half/word accesses.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_B:  mask = 4'b0001 << addr_lo;
      SIZE_H:  mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational RV32I byte-lane placement for stores and extraction/extension for loads
//   size_i     : access size (dmem_pkg encodings)
//   addr_lo_i  : byte address bits [1:0]
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   wdata_i    : right-aligned store data
//   rword_i    : full memory word being read
//   wmask_o    : byte-lane write enables
//   wdata_o    : store data replicated onto every candidate lane
//   rdata_o    : right-aligned, extended load result
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_bit;

  assign wmask_o = lane_mask(size_i, addr_lo_i);

  // Replicating the data means the mask alone picks the target lane.
  always_comb begin
    wdata_o = wdata_i;
    case (size_i)
      SIZE_B:  wdata_o = {4{wdata_i[7:0]}};
      SIZE_H:  wdata_o = {2{wdata_i[15:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  always_comb begin
    byte_sel = rword_i[8*addr_lo_i +: 8];
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    sign_bit = 1'b0;
    rdata_o  = rword_i;
    case (size_i)
      SIZE_B: begin
        sign_bit = ~unsigned_i & byte_sel[7];
        rdata_o  = {{24{sign_bit}}, byte_sel};
      end
      SIZE_H: begin
        sign_bit = ~unsigned_i & half_sel[15];
        rdata_o  = {{16{sign_bit}}, half_sel};
      end
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory target with wait states, lane alignment and error response
//   clk_i, rst_i (async, active low)
//   req_valid_i/req_ready_o : request handshake; req_we_i, req_addr_i, req_wdata_i,
//                             req_size_i, req_unsigned_i sampled only at accept
//   rsp_valid_o/rsp_ready_i : response handshake; rsp_rdata_o, rsp_err_o held while valid
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [2:0]  LAT_INIT  = 3'(LATENCY);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  acc_err;
  logic                  access;
  logic                  mem_we;
  logic [31:0]           mem_rword;
  logic [3:0]            wmask;
  logic [31:0]           wdata_rep;
  logic [31:0]           load_data;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range check.
  assign offset   = addr_q - BASE_ADDR;
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign acc_err  = (size_q == 2'b11)
                 || ((size_q == SIZE_H) && addr_q[0])
                 || ((size_q == SIZE_W) && (addr_q[1:0] != 2'b00))
                 || ({1'b0, offset} >= MEM_BYTES);

  assign access    = (state_q == ST_BUSY) && (cnt_q == 3'd0);
  assign mem_we    = access && we_q && !acc_err;
  assign mem_rword = mem[word_idx];

  dmem_lane_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rword_i    (mem_rword),
    .wmask_o    (wmask),
    .wdata_o    (wdata_rep),
    .rdata_o    (load_data)
  );

  // Ready is gated by rst_i so it reads 0 while reset is held.
  assign req_ready_o = (state_q == ST_IDLE) && rst_i;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          cnt_d   = LAT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'h0 : load_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is not reset; an asserted reset forces IDLE, which blocks mem_we.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

endmodule
